// File: rtl/vga_linebuf_pp.sv
// Ping-pong line buffer: the system side fills the back bank while the scanner
// streams the front bank; banks swap at a line start once the back is complete.
module vga_linebuf_pp #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic [AW-1:0] sys_addr,
    input  logic [DW-1:0] sys_dati,
    input  logic          sys_we,
    input  logic          sys_ce,
    output logic [DW-1:0] sys_dato,
    input  logic          sys_done,
    output logic          sys_ready,
    input  logic          pix_start,
    input  logic          pix_en,
    input  logic [AW:0]   line_len,
    output logic [DW-1:0] pix_dato,
    output logic          pix_valid,
    output logic          pix_line_done,
    output logic          pix_busy,
    output logic [7:0]    underrun_cnt
);

    typedef enum logic {FILLING, FULL} back_state_e;
    typedef enum logic {IDLE, SCAN} scan_state_e;

    localparam int          DEPTH   = 2 ** (AW + 1);
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [DEPTH];

    logic          bank_sel_q, bank_sel_d;
    back_state_e   back_q, back_d;
    scan_state_e   scan_q, scan_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [7:0]    und_q, und_d;
    logic          line_done_d;
    logic [DW-1:0] sys_dato_q, pix_dato_q;
    logic          pix_valid_q, line_done_q;

    logic swap, sys_wr, sys_rd, pix_rd, pix_last;

    // A same-cycle sys_done completes the bank, so the swap can happen right away.
    assign swap     = pix_start && (back_q == FULL || sys_done);
    assign sys_wr   = sys_ce && sys_we && back_q == FILLING;
    assign sys_rd   = sys_ce && !sys_we;
    assign pix_rd   = scan_q == SCAN && !pix_start && len_q != '0 && pix_en;
    assign pix_last = ptr_q == len_q - (AW + 1)'(1);

    // NOTE: every signal assigned here gets its default first, so no latch is inferred.
    always_comb begin
        bank_sel_d  = bank_sel_q;
        back_d      = back_q;
        und_d       = und_q;
        scan_d      = scan_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        line_done_d = 1'b0;

        if (swap) begin
            bank_sel_d = ~bank_sel_q;
            back_d     = FILLING;
        end else begin
            if (sys_done) back_d = FULL;
            if (pix_start && und_q != 8'hFF) und_d = und_q + 8'd1;
        end

        if (pix_start) begin
            len_d  = (line_len > MAX_LEN) ? MAX_LEN : line_len;
            ptr_d  = '0;
            scan_d = SCAN;
        end else if (scan_q == SCAN) begin
            if (len_q == '0) begin
                scan_d = IDLE;
            end else if (pix_en) begin
                ptr_d = ptr_q + (AW + 1)'(1);
                if (pix_last) begin
                    scan_d      = IDLE;
                    line_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bank_sel_q  <= 1'b0;
            back_q      <= FILLING;
            scan_q      <= IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            und_q       <= '0;
            sys_dato_q  <= '0;
            pix_dato_q  <= '0;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            bank_sel_q  <= bank_sel_d;
            back_q      <= back_d;
            scan_q      <= scan_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            und_q       <= und_d;
            pix_valid_q <= pix_rd;
            line_done_q <= line_done_d;
            if (sys_rd) sys_dato_q <= mem[{~bank_sel_q, sys_addr}];
            if (pix_rd) pix_dato_q <= mem[{bank_sel_q, ptr_q[AW-1:0]}];
        end
    end

    // NOTE: the RAM is deliberately left out of reset so it maps onto block memory.
    always_ff @(posedge sys_clk) begin
        if (sys_wr) mem[{~bank_sel_q, sys_addr}] <= sys_dati;
    end

    assign sys_dato      = sys_dato_q;
    assign sys_ready     = back_q == FILLING;
    assign pix_dato      = pix_dato_q;
    assign pix_valid     = pix_valid_q;
    assign pix_line_done = line_done_q;
    assign pix_busy      = scan_q == SCAN;
    assign underrun_cnt  = und_q;

endmodule

// File: tb/tb_vga_linebuf_pp.sv
// Self-checking bench for vga_linebuf_pp: directed scenarios, a vector table,
// and random traffic compared against a transaction-level model.
module tb_vga_linebuf_pp;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int WORDS = 2 ** AW;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sys_addr;
    logic [DW-1:0] sys_dati;
    logic          sys_we, sys_ce, sys_done;
    logic [DW-1:0] sys_dato;
    logic          sys_ready;
    logic          pix_start, pix_en;
    logic [AW:0]   line_len;
    logic [DW-1:0] pix_dato;
    logic          pix_valid, pix_line_done, pix_busy;
    logic [7:0]    underrun_cnt;

    vga_linebuf_pp #(.DW(DW), .AW(AW)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .sys_addr(sys_addr), .sys_dati(sys_dati), .sys_we(sys_we), .sys_ce(sys_ce),
        .sys_dato(sys_dato), .sys_done(sys_done), .sys_ready(sys_ready),
        .pix_start(pix_start), .pix_en(pix_en), .line_len(line_len),
        .pix_dato(pix_dato), .pix_valid(pix_valid), .pix_line_done(pix_line_done),
        .pix_busy(pix_busy), .underrun_cnt(underrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: two banks as arrays, a completion flag, and the line
    // being scanned held as a queue of words still to be emitted.
    logic [7:0] m_mem [2][WORDS];
    logic       m_sel, m_full, m_active, m_valid, m_done;
    int         m_und;
    logic [7:0] m_sys_dato, m_pix_dato;
    logic [7:0] m_line [$];

    task automatic model_reset();
        m_sel = 0; m_full = 0; m_active = 0; m_valid = 0; m_done = 0; m_und = 0;
        m_sys_dato = 0; m_pix_dato = 0;
        m_line.delete();
    endtask

    task automatic model_update();
        bit swap;
        int n;
        swap = pix_start && (m_full || sys_done);
        m_valid = 0;
        m_done  = 0;
        if (sys_ce && !sys_we) m_sys_dato = m_mem[!m_sel][sys_addr];
        if (sys_ce && sys_we && !m_full) m_mem[!m_sel][sys_addr] = sys_dati;
        if (swap) begin
            m_sel  = !m_sel;
            m_full = 0;
        end else begin
            if (sys_done) m_full = 1;
            if (pix_start && m_und < 255) m_und++;
        end
        if (pix_start) begin
            n = (int'(line_len) > WORDS) ? WORDS : int'(line_len);
            m_line.delete();
            for (int i = 0; i < n; i++) m_line.push_back(m_mem[m_sel][i]);
            m_active = 1;
        end else if (m_active) begin
            if (m_line.size() == 0) begin
                m_active = 0;
            end else if (pix_en) begin
                m_pix_dato = m_line.pop_front();
                m_valid = 1;
                if (m_line.size() == 0) begin
                    m_done   = 1;
                    m_active = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        if (rst) model_reset();
        else model_update();
        #1;
        check("sys_ready", sys_ready, m_full ? 0 : 1);
        check("sys_dato", sys_dato, m_sys_dato);
        check("pix_dato", pix_dato, m_pix_dato);
        check("pix_valid", pix_valid, m_valid);
        check("pix_line_done", pix_line_done, m_done);
        check("pix_busy", pix_busy, m_active);
        check("underrun_cnt", underrun_cnt, m_und);
    endtask

    task automatic clear_inputs();
        sys_addr = '0; sys_dati = '0; sys_we = 0; sys_ce = 0; sys_done = 0;
        pix_start = 0; pix_en = 0; line_len = '0;
    endtask

    typedef struct {
        logic        start;
        logic        en;
        logic        exp_valid;
        logic [7:0]  exp_dato;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int nval, ndone, nbusy;
        logic [7:0] v0;
        logic [7:0] words [4];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h5B, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h5B, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h5B, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h58, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};

        clear_inputs();
        rst = 1;
        repeat (3) step();
        check("rst sys_ready", sys_ready, 1);
        check("rst pix_busy", pix_busy, 0);
        check("rst pix_valid", pix_valid, 0);
        check("rst pix_line_done", pix_line_done, 0);
        check("rst pix_dato", pix_dato, 0);
        check("rst sys_dato", sys_dato, 0);
        check("rst underrun", underrun_cnt, 0);
        rst = 0;

        // Fill, complete, swap, then scan a full line with pix_en held high.
        for (int i = 0; i < WORDS; i++) begin
            sys_ce = 1; sys_we = 1; sys_addr = AW'(i); sys_dati = 8'(i) ^ 8'h5A;
            step();
        end
        clear_inputs();
        sys_done = 1;
        step();
        clear_inputs();
        pix_start = 1; line_len = (AW + 1)'(16);
        step();
        check("swap sys_ready", sys_ready, 1);
        pix_start = 0; pix_en = 1;
        nval = 0; ndone = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (pix_valid) begin
                check("line1 pix_dato", pix_dato, 8'(nval) ^ 8'h5A);
                nval++;
                if (pix_line_done) begin
                    ndone++;
                    check("line1 done position", nval, 16);
                end
            end
        end
        check("line1 valid count", nval, 16);
        check("line1 done count", ndone, 1);

        // Line start without a completed back bank repeats the line.
        clear_inputs();
        pix_start = 1; line_len = (AW + 1)'(16);
        step();
        pix_start = 0; pix_en = 1;
        step();
        check("repeat first word", pix_dato, 8'h5A);
        check("underrun one", underrun_cnt, 1);
        clear_inputs();
        line_len = (AW + 1)'(16);
        pix_start = 1;
        repeat (300) step();
        check("underrun saturate", underrun_cnt, 255);
        clear_inputs();
        step();

        // Writes after completion are dropped, reads still work.
        for (int i = 0; i < WORDS; i++) begin
            sys_ce = 1; sys_we = 1; sys_addr = AW'(i); sys_dati = 8'($urandom);
            if (i == 0) v0 = sys_dati;
            step();
        end
        clear_inputs();
        sys_done = 1;
        step();
        clear_inputs();
        sys_ce = 1; sys_we = 1; sys_addr = '0; sys_dati = 8'hFF;
        step();
        sys_we = 0;
        step();
        check("full sys_ready", sys_ready, 0);
        check("dropped write readback", sys_dato, v0);
        clear_inputs();
        step();

        // Reset keeps RAM; then done + write + start all in one cycle.
        rst = 1;
        repeat (2) step();
        rst = 0;
        sys_done = 1; sys_ce = 1; sys_we = 1; sys_addr = AW'(3); sys_dati = 8'h77;
        pix_start = 1; line_len = (AW + 1)'(4);
        step();
        clear_inputs();
        pix_en = 1; line_len = (AW + 1)'(4);
        nval = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (pix_valid && nval < 4) begin
                words[nval] = pix_dato;
                nval++;
            end
        end
        check("same-cycle word0", words[0], 8'h5A);
        check("same-cycle word3", words[3], 8'h77);
        check("same-cycle underrun", underrun_cnt, 0);
        check("same-cycle sys_ready", sys_ready, 1);

        // Gapped pix_en and an abort after two words.
        clear_inputs();
        for (int v = 0; v < 10; v++) begin
            pix_start = vecs[v].start; pix_en = vecs[v].en; line_len = (AW + 1)'(4);
            step();
            check($sformatf("vec%0d pix_valid", v), pix_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d pix_dato", v), pix_dato, vecs[v].exp_dato);
            check($sformatf("vec%0d pix_line_done", v), pix_line_done, vecs[v].exp_done);
            check($sformatf("vec%0d pix_busy", v), pix_busy, vecs[v].exp_busy);
        end

        // Zero-length line and an over-long line.
        clear_inputs();
        pix_start = 1; line_len = '0;
        step();
        nbusy = pix_busy ? 1 : 0;
        nval = 0;
        pix_start = 0; pix_en = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            nbusy += pix_busy ? 1 : 0;
            nval  += pix_valid ? 1 : 0;
        end
        check("len0 busy cycles", nbusy, 1);
        check("len0 valid count", nval, 0);
        pix_start = 1; line_len = (AW + 1)'(WORDS + 5);
        step();
        pix_start = 0;
        nval = 0; ndone = 0;
        for (int c = 0; c < WORDS + 10; c++) begin
            step();
            nval  += pix_valid ? 1 : 0;
            ndone += pix_line_done ? 1 : 0;
        end
        check("clamped valid count", nval, WORDS);
        check("clamped done count", ndone, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            sys_ce    = ($urandom_range(0, 3) != 0);
            sys_we    = $urandom_range(0, 1);
            sys_addr  = AW'($urandom);
            sys_dati  = 8'($urandom);
            sys_done  = ($urandom_range(0, 19) == 0);
            pix_start = ($urandom_range(0, 24) == 0);
            pix_en    = ($urandom_range(0, 3) != 0);
            line_len  = (AW + 1)'($urandom_range(0, WORDS + 4));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_linebuf_pp.md
# vga_linebuf_pp

Parametrised single-clock ping-pong line buffer for the VGA path. The system side fills the back bank through a CPU-style port while a pixel scanner streams the front bank out under a pixel-enable strobe. Banks swap only at a line start and only when the back bank has been declared complete; otherwise the front line is repeated and an underrun is counted. It sits between the bus-side frame writer and the pixel serialiser and adds bank handshaking and variable line length.

## Interface
Parameters:
- DW, 8: data width in bits.
- AW, 11: address width; each bank holds 2**AW words, 2 banks total.

Ports:
- sys_clk  in  1  sole clock for both sides.
- rst  in  1  synchronous, active-high reset.
- sys_addr  in  AW  back-bank word address.
- sys_dati  in  DW  write data.
- sys_we  in  1  write enable, qualified by sys_ce.
- sys_ce  in  1  access enable.
- sys_dato  out  DW  registered back-bank read data.
- sys_done  in  1  pulse: back bank is complete.
- sys_ready  out  1  1 = back bank accepts writes (FILLING).
- pix_start  in  1  pulse: begin scanning a line.
- pix_en  in  1  pixel strobe; one word per asserted cycle while scanning.
- line_len  in  AW+1  words per line, sampled on pix_start.
- pix_dato  out  DW  registered pixel data.
- pix_valid  out  1  pix_dato is valid this cycle.
- pix_line_done  out  1  pulse coincident with the last pix_valid of a line.
- pix_busy  out  1  scanner in SCAN.
- underrun_cnt  out  8  saturating count of line starts without a ready back bank.

## Operation
- bank_sel register: front = bank_sel, back = ~bank_sel.
- Back-bank FSM, FILLING/FULL:
  - FILLING: accesses are allowed. With sys_ce & sys_we, write back[sys_addr]. With sys_ce & !sys_we, sys_dato <= back[sys_addr].
  - sys_done in FILLING -> FULL. sys_done in FULL is ignored.
  - FULL: writes are dropped, reads still allowed, and sys_ready = 0.
- Swap:
  - Condition: pix_start && (state == FULL || sys_done). sys_done in the same cycle counts as done; a write in that cycle lands before the swap.
  - Action: toggle bank_sel, back FSM -> FILLING.
  - Without the swap condition, pix_start rescans the current front and increments underrun_cnt, saturating at 255.
- Scanner FSM, IDLE/SCAN:
  - pix_start in any state captures len = min(line_len, 2**AW), resets the read pointer to 0 and enters SCAN. A pix_start during SCAN aborts the current line; pix_line_done is not asserted for the aborted line.
  - len = 0: scanner stays/returns IDLE and produces no pixels.
  - In SCAN, each pix_en reads front[ptr] and increments ptr. On the pix_en that consumes word len-1 the scanner returns to IDLE.
  - pix_en in IDLE is ignored.
- sys_dato holds its value when not reading.
- pix_dato holds the last pixel when pix_valid = 0.
- Reset values: bank_sel 0, back FILLING, scanner IDLE, sys_ready 1, pix_busy 0, pix_valid 0, pix_line_done 0, pix_dato 0, sys_dato 0, underrun_cnt 0. Reset mid-line or mid-fill discards all progress; RAM contents are not cleared.

## Timing
- sys read: address at cycle T, sys_dato valid at T+1.
- pix_start at T: pix_busy = 1 from T+1. The earliest accepted pix_en is at T+1.
- pix_en at cycle C: pix_dato/pix_valid at C+1, with no bubbles for back-to-back pix_en.
- pix_line_done coincides with the pix_valid of word len-1. pix_busy falls in the cycle after the last pix_en.
- Swap at pix_start T: sys_ready = 1 from T+1. The first pixel read at T+1 already comes from the new front.
- sys_done at T, without a swap: sys_ready = 0 from T+1. A write at T is accepted.
- Address wrap is not possible, because len is clamped to 2**AW.

## Test plan
- Reset, fill back with data = addr ^ 8'h5A for 0..15, then sys_done, then pix_start with line_len = 16 and pix_en held high. Required: 16 pix_valid cycles with pix_dato = addr ^ 8'h5A, and pix_line_done on the 16th; sys_ready = 1 after the swap.
- pix_start without a prior sys_done: the previous line repeats and underrun_cnt increments to 1. Repeat 300 times: underrun_cnt saturates at 255.
- After sys_done, write 8'hFF to addr 0, then read addr 0. Required: write dropped, sys_ready = 0, sys_dato shows the old value one cycle after the read.
- sys_done, a write of 8'h77 to addr 3, and pix_start all in the same cycle. Required: swap occurs, the scanned word 3 = 8'h77, and underrun_cnt is unchanged.
- pix_en toggled 1,0,1,1 during a line of 4, then pix_start after 2 words. Required: pix_valid follows pix_en by one cycle, the abort restarts at addr 0, and pix_line_done fires only for the completed line.
- line_len = 0 gives no pix_valid and pix_busy = 1 for exactly one cycle. line_len = 2**AW + 5 scans exactly 2**AW words.
